// File: rtl/fp_adder_pipe.sv
`default_nettype none
// ============================================================================
// fp_adder_pipe : three-stage pipelined floating-point adder, RNE, flush-to-zero
// Revision 1.0
// ============================================================================
module fp_adder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     number_1,
  input  logic [EXP_W+MAN_W:0]     number_2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out,
  output logic [2:0]               flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int F   = MAN_W + 3;           // hidden + fraction + guard + round
  localparam int M   = MAN_W + 4;           // F plus sticky
  localparam int S   = MAN_W + 5;           // M plus carry
  localparam int LZW = $clog2(M + 1);
  localparam int XW  = EXP_W + LZW + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  logic s1_valid_q, s2_valid_q, out_valid_q;
  logic [W-1:0] out_q;
  logic [2:0]   flags_q;

  assign adv       = out_ready | ~out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

  // ---------------- S1: unpack, classify, compare, align ----------------
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;

  assign {a_s, a_e, a_m} = number_1;
  assign {b_s, b_e, b_m} = number_2;
  assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_big  = {a_e, a_m} >= {b_e, b_m};

  logic             s1_spec_d, s1_spec_q;
  logic [W-1:0]     s1_sword_d, s1_sword_q;
  logic [2:0]       s1_sflag_d, s1_sflag_q;
  logic             s1_sign_d, s1_sign_q, s1_sub_q;
  logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
  logic [M-1:0]     s1_big_d, s1_big_q, s1_small_d, s1_small_q;
  logic [MAN_W-1:0] small_m;
  logic [EXP_W-1:0] diff;
  logic [15:0]      shamt;
  logic [2*F-1:0]   align;

  always_comb begin
    s1_spec_d  = 1'b1;
    s1_sword_d = '0;
    s1_sflag_d = 3'b000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
      s1_sword_d = QNAN;
      s1_sflag_d = 3'b100;
    end else if (a_inf) begin
      s1_sword_d = {a_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_sword_d = {b_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_sword_d = {a_s & b_s, {(W-1){1'b0}}};
    end else if (a_zero) begin
      s1_sword_d = number_2;
    end else if (b_zero) begin
      s1_sword_d = number_1;
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  // Shift is clamped at F so the whole smaller operand lands in the sticky field.
  always_comb begin
    s1_sign_d  = a_big ? a_s : b_s;
    s1_exp_d   = a_big ? a_e : b_e;
    s1_big_d   = {1'b1, (a_big ? a_m : b_m), 3'b000};
    small_m    = a_big ? b_m : a_m;
    diff       = a_big ? (a_e - b_e) : (b_e - a_e);
    shamt      = (16'(diff) >= 16'(F)) ? 16'(F) : 16'(diff);
    align      = {1'b1, small_m, 2'b00, {F{1'b0}}} >> shamt;
    s1_small_d = {align[2*F-1:F], |align[F-1:0]};
  end

  // ---------------- S2: signed magnitude add/subtract ----------------
  logic [S-1:0]     s2_sum_d, s2_sum_q;
  logic             s2_sign_q, s2_spec_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [W-1:0]     s2_sword_q;
  logic [2:0]       s2_sflag_q;

  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                             : ({1'b0, s1_big_q} + {1'b0, s1_small_q});

  // ---------------- S3: normalise, round, pack ----------------
  function automatic logic [LZW-1:0] lzc(input logic [M-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(M);
    for (int i = 0; i < M; i++) begin
      if (v[i]) n = LZW'(M - 1 - i);
    end
    return n;
  endfunction

  logic             carry, round_up;
  logic [LZW-1:0]   lz;
  logic [M-1:0]     norm;
  logic [MAN_W+1:0] mant_r;
  logic [XW-1:0]    exp_n, exp_f;
  logic [W-1:0]     res_d;
  logic [2:0]       flg_d;

  always_comb begin
    carry = s2_sum_q[S-1];
    lz    = lzc(s2_sum_q[M-1:0]);
    exp_n = XW'(s2_exp_q);
    if (carry) begin
      norm  = {s2_sum_q[S-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = exp_n + XW'(1);
    end else begin
      norm  = s2_sum_q[M-1:0] << lz;
      exp_n = exp_n - XW'(lz);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[M-1:3]} + (MAN_W+2)'(round_up);
    exp_f    = exp_n + XW'(mant_r[MAN_W+1]);
    res_d    = {s2_sign_q, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
    flg_d    = 3'b000;
    if (s2_spec_q) begin
      res_d = s2_sword_q;
      flg_d = s2_sflag_q;
    end else if (s2_sum_q == '0) begin
      res_d = '0;
    end else if (exp_f[XW-1] || (exp_f == '0)) begin
      res_d = {s2_sign_q, {(W-1){1'b0}}};
      flg_d = 3'b001;
    end else if (exp_f >= XW'(EXP_ONES)) begin
      res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      flg_d = 3'b010;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= 3'b000;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_q   <= res_d;
        flags_q <= flg_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_spec_q  <= s1_spec_d;
      s1_sword_q <= s1_sword_d;
      s1_sflag_q <= s1_sflag_d;
      s1_sign_q  <= s1_sign_d;
      s1_sub_q   <= a_s ^ b_s;
      s1_exp_q   <= s1_exp_d;
      s1_big_q   <= s1_big_d;
      s1_small_q <= s1_small_d;
    end
    if (adv && s1_valid_q) begin
      s2_sum_q   <= s2_sum_d;
      s2_sign_q  <= s1_sign_q;
      s2_exp_q   <= s1_exp_q;
      s2_spec_q  <= s1_spec_q;
      s2_sword_q <= s1_sword_q;
      s2_sflag_q <= s1_sflag_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_pipe.sv
`default_nettype none
// ============================================================================
// tb_fp_adder_pipe : scoreboard bench for fp_adder_pipe against an exact RNE/FTZ model
// Revision 1.0
// ============================================================================
module tb_fp_adder_pipe;
  localparam int NRAND = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] number_1 = '0;
  logic [31:0] number_2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic [2:0]  flags;

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  logic [34:0] sb[$];
  logic [98:0] dir [0:16];
  logic        rnd_on;
  logic [31:0] ra, rb;
  int          rea, reb, lat, n;
  logic [34:0] cap;

  always #5 clk = ~clk;

  fp_adder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .number_1  (number_1),
    .number_2  (number_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Exact integer reference: align on a wide vector, add, then round to nearest even.
  function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, r, kept, rem, half, one;
    int ea, eb, emin, p, k, e;
    logic sr, a_nan, b_nan, a_inf, b_inf;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return {3'b100, 32'h7FC00000};
    if (a_inf) return {3'b000, a};
    if (b_inf) return {3'b000, b};
    if (ea == 0 && eb == 0) return {3'b000, a[31] & b[31], 31'b0};
    if (ea == 0) return {3'b000, b};
    if (eb == 0) return {3'b000, a};
    one  = 300'd1;
    ma   = {276'b0, 1'b1, a[22:0]};
    mb   = {276'b0, 1'b1, b[22:0]};
    emin = (ea < eb) ? ea : eb;
    ma   = ma << (ea - emin);
    mb   = mb << (eb - emin);
    if (a[31] == b[31]) begin r = ma + mb; sr = a[31]; end
    else if (ma >= mb)  begin r = ma - mb; sr = a[31]; end
    else                begin r = mb - ma; sr = b[31]; end
    if (r == 0) return 35'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (r[i]) p = i;
    e = emin + p - 23;
    if (p > 23) begin
      k    = p - 23;
      kept = r >> k;
      rem  = r & ((one << k) - one);
      half = one << (k - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + one;
      if (kept[24]) begin kept = kept >> 1; e = e + 1; end
    end else begin
      kept = r << (23 - p);
    end
    if (e <= 0)   return {3'b001, sr, 31'b0};
    if (e >= 255) return {3'b010, sr, 8'hFF, 23'b0};
    return {3'b000, sr, e[7:0], kept[22:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the pair has been taken.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp);
    int w = 0;
    in_valid = 1'b1;
    number_1 = a;
    number_2 = b;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: in_ready observed 0 required 1");
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    do begin @(posedge clk); w++; end while (sb.size() != 0 && w < 500);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: outstanding %0d required 0", sb.size());
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_result: observed %h required none", {flags, out});
      end
      if (sb.size() != 0) chk("result", {flags, out}, sb.pop_front());
      delivered++;
    end
  end

  initial begin
    dir[0]  = {32'h40200000, 32'h40600000, 3'b000, 32'h40C00000};
    dir[1]  = {32'h40600000, 32'hC0000000, 3'b000, 32'h3FC00000};
    dir[2]  = {32'h3F800000, 32'h33800000, 3'b000, 32'h3F800000};
    dir[3]  = {32'h3F800000, 32'hBF800000, 3'b000, 32'h00000000};
    dir[4]  = {32'h7F7FFFFF, 32'h7F7FFFFF, 3'b010, 32'h7F800000};
    dir[5]  = {32'h7F800000, 32'hFF800000, 3'b100, 32'h7FC00000};
    dir[6]  = {32'h00400000, 32'h00000000, 3'b000, 32'h00000000};
    dir[7]  = {32'h7FC00001, 32'h3F800000, 3'b100, 32'h7FC00000};
    dir[8]  = {32'hFF800000, 32'h3F800000, 3'b000, 32'hFF800000};
    dir[9]  = {32'h80000000, 32'h80000000, 3'b000, 32'h80000000};
    dir[10] = {32'h00000000, 32'hBF800000, 3'b000, 32'hBF800000};
    dir[11] = {32'h3F800001, 32'h33800000, 3'b000, 32'h3F800002};
    dir[12] = {32'h00800001, 32'h80800000, 3'b001, 32'h00000000};
    dir[13] = {32'hFF7FFFFF, 32'hFF7FFFFF, 3'b010, 32'hFF800000};
    dir[14] = {32'h7F800000, 32'h7F800000, 3'b000, 32'h7F800000};
    dir[15] = {32'h3F800000, 32'h3F800000, 3'b000, 32'h40000000};
    dir[16] = {32'h3F800000, 32'h33800001, 3'b000, 32'h3F800001};

    // Reset state
    #1;
    chk("reset_out_valid", 35'(out_valid), 35'd0);
    chk("reset_out_flags", {flags, out}, 35'd0);
    chk("reset_in_ready", 35'(in_ready), 35'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency of the first operation
    in_valid = 1'b1;
    number_1 = dir[0][98:67];
    number_2 = dir[0][66:35];
    @(negedge clk);
    chk("first_accept_ready", 35'(in_ready), 35'd1);
    sb.push_back(dir[0][34:0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("latency", 35'(lat), 35'd3);
    @(posedge clk);
    #1;

    // Directed vectors, back to back
    for (int i = 1; i < 17; i++) send(dir[i][98:67], dir[i][66:35], dir[i][34:0]);
    drain();

    // Six-deep stream with a five-cycle downstream stall after the second result
    n = delivered;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = 32'h3F800000 + 32'(i * 32'h00123457);
          rb = 32'hBF000000 - 32'(i * 32'h00054321);
          send(ra, rb, ref_add(ra, rb));
        end
      end
      begin
        lat = 0;
        while (delivered < n + 2 && lat < 200) begin @(posedge clk); lat++; end
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        cap = {flags, out};
        chk("stall_out_valid", 35'(out_valid), 35'd1);
        chk("stall_in_ready", 35'(in_ready), 35'd0);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("stall_in_ready", 35'(in_ready), 35'd0);
          chk("stall_hold", {flags, out}, cap);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_delivered", 35'(delivered - n), 35'd6);

    // Reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h40000000 + 32'(i), 32'h3F800000, ref_add(32'h40000000 + 32'(i), 32'h3F800000));
    chk("inflight_out_valid", 35'(out_valid), 35'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 35'(out_valid), 35'd0);
    chk("async_reset_out_flags", {flags, out}, 35'd0);
    chk("async_reset_in_ready", 35'(in_ready), 35'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_quiet", 35'(out_valid), 35'd0);

    // Random normal operands with random downstream back-pressure
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          rea = int'($urandom_range(254, 1));
          case ($urandom_range(3, 0))
            0: reb = int'($urandom_range(254, 1));
            3: begin
              if ($urandom_range(1, 0) == 1) begin
                rea = int'($urandom_range(254, 248)); reb = int'($urandom_range(254, 248));
              end else begin
                rea = int'($urandom_range(30, 1)); reb = int'($urandom_range(30, 1));
              end
            end
            default: begin
              reb = rea + int'($urandom_range(6, 0)) - 3;
              if (reb < 1) reb = 1;
              if (reb > 254) reb = 254;
            end
          endcase
          ra = {1'($urandom), rea[7:0], 23'($urandom)};
          rb = {1'($urandom), reb[7:0], 23'($urandom)};
          send(ra, rb, ref_add(ra, rb));
          if ($urandom_range(9, 0) == 0) begin @(posedge clk); #1; end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          if (rnd_on) out_ready = ($urandom_range(3, 0) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
